nch_complex_square: RTL and testbench
=====================================

Name: nch_complex_square

Overview:
- Parametrised N-lane complex squarer with a valid/ready stream interface and a 3-stage pipeline.
- Each lane computes either z^2 or |z|^2 of a signed fixed-point complex sample.
- Sits in the dotProduct datapath ahead of the sorter's metric accumulation.
- Adds backpressure, mode select, scaling and saturation reporting to the fixed four-lane squarer.

Parameters:
- WIDTH, 16, signed bit width of each real/imag component, in and out.
- NCH, 4, number of parallel complex lanes (>=1).
- FRAC, 14, fractional bits of the fixed-point format (1 <= FRAC < WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- inReal  in  NCH*WIDTH  lane k real part at bits [k*WIDTH +: WIDTH], signed.
- inImag  in  NCH*WIDTH  lane k imag part, same packing.
- inMode  in  1  0 = complex square z^2; 1 = magnitude squared |z|^2; sampled with the data.
- inValid  in  1  input beat valid.
- inReady  out  1  block accepts the beat this cycle.
- outReal  out  NCH*WIDTH  result real parts, same packing.
- outImag  out  NCH*WIDTH  result imag parts; all zero in mode 1.
- outValid  out  1  result beat valid.
- outReady  in  1  downstream accepts the result.
- satFlag  out  NCH  per-lane flag: that lane's real or imag result saturated; qualified by outValid.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: every pipeline valid bit cleared, all data registers cleared to 0, so outValid=0, outReal/outImag=0, satFlag=0.
- Reset mid-stream: in-flight beats are discarded, with no partial output.
- Pipeline: 3 stages, S1 = input capture, S2 = products, S3 = combine/scale/saturate/output register.
- Latency: 3 cycles from the accepting edge to outValid when there is no stall. Throughput is 1 beat/cycle.
- Global stall: adv = !outValid | outReady; inReady = adv, purely combinational from outValid and outReady.
- Advance rule: all stages advance together when adv=1 and hold when adv=0.
- Beat acceptance: a beat is accepted on inValid & inReady.
- Stalled output: while outValid=1 & outReady=0, outReal/outImag/satFlag stay stable.
- Bubbles: bubbles (inValid=0) propagate as valid=0 stages. Data in bubble stages is don't-care, but outputs are only observed with outValid.
- S2 products per lane, with a=real and b=imag: P_aa = a*a, P_bb = b*b, P_ab = a*b, each signed 2*WIDTH bits.
- S3, mode 0: R = P_aa - P_bb, I = 2*P_ab.
- S3, mode 1: R = P_aa + P_bb, I = 0.
- Intermediates are 2*WIDTH+2 bits signed, so no internal overflow.
- Scaling: arithmetic right shift by FRAC (floor toward -inf).
- Saturation: clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. satFlag[k] = clamp occurred on R or I of lane k.
- Mode tagging: mode travels with its beat; changing inMode between beats affects only the beats sampled with the new value.

Optional Feature:
- Macro: NCH_CSQ_ROUND_EN.
- Defined: add 2^(FRAC-1) before the shift (round half toward +inf), applied before saturation.
- Undefined: plain truncation (floor).
- Latency and interface are identical in both builds.

Decomposition:
- Package nch_csq_pkg: CSQ_LATENCY=3; MODE_SQUARE=1'b0 and MODE_MAG2=1'b1; a saturate function parametrised by input/output width.
- Sub-module complex_square_lane: one lane's S2/S3 datapath, with a shared stage-enable input. Instantiate NCH times via generate.
- Valid/ready and mode control stay in the top level.

Test Plan:
- Defaults (WIDTH=16, FRAC=14), mode 0, lane0 = 8192+8192j (0.5+0.5j) -> after 3 cycles outReal=0, outImag=8192, satFlag[0]=0.
- Mode 1, same input -> outReal=8192, outImag=0. Then mode 0 with 16384+0j -> outReal=16384, outImag=0.
- Lane0 = -32768+0j in mode 0 -> outReal=32767 (saturated), satFlag[0]=1. Other lanes carrying 0 -> outputs 0, flags 0.
- Lane0 = 91+0j -> outReal=0 without macro, 1 with NCH_CSQ_ROUND_EN. Lane0 = 0+91j -> outReal=-1 in both builds.
- Stream 10 beats of distinct values with outReady held low for cycles 4-7 -> inReady low during the stall, outputs stable, no beat lost or duplicated, order preserved.
- Assert rst asynchronously with 3 beats in flight -> outValid=0 and outputs 0 immediately. After release, the first output appears 3 cycles after the next accepted beat.

Source files
------------

// File: rtl/nch_csq_pkg.sv
// Shared constants and the saturation helper for the N-lane complex squarer.
package nch_csq_pkg;

    localparam int   CSQ_LATENCY = 3;
    localparam logic MODE_SQUARE = 1'b0;
    localparam logic MODE_MAG2   = 1'b1;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] value;
    } satResult_t;

    // Sign-extends the low inW bits of raw, then clamps to a signed outW range.
    function automatic satResult_t saturate(input logic [63:0] raw, input int inW, input int outW);
        satResult_t         res;
        logic signed [63:0] val;
        logic signed [63:0] maxV;
        logic signed [63:0] minV;
        val  = $signed(raw << (64 - inW));
        val  = val >>> (64 - inW);
        maxV = (64'sd1 <<< (outW - 1)) - 64'sd1;
        minV = -maxV - 64'sd1;
        res.sat   = 1'b0;
        res.value = val;
        if (val > maxV) begin
            res.sat   = 1'b1;
            res.value = maxV;
        end else if (val < minV) begin
            res.sat   = 1'b1;
            res.value = minV;
        end
        return res;
    endfunction

endpackage

// File: rtl/complex_square_lane.sv
// One lane of the squarer: S2 products and S3 combine/scale/saturate register.
// NCH_CSQ_ROUND_EN selects round-half-up scaling instead of floor.
module complex_square_lane
    import nch_csq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stageEn,
    input  logic signed [WIDTH-1:0] s1Real,
    input  logic signed [WIDTH-1:0] s1Imag,
    input  logic                    s2Mode,
    output logic        [WIDTH-1:0] outReal,
    output logic        [WIDTH-1:0] outImag,
    output logic                    satFlag
);

    localparam int PW = 2 * WIDTH;
    localparam int IW = 2 * WIDTH + 2;

    logic signed [PW-1:0] aExt, bExt;
    logic signed [PW-1:0] pAA, pBB, pAB;
    logic signed [IW-1:0] pAAx, pBBx, pABx;
    logic signed [IW-1:0] sumR, sumI;
    logic signed [IW-1:0] shR, shI;
    satResult_t           satR, satI;
    logic                 unusedHigh;

    assign aExt = {{WIDTH{s1Real[WIDTH-1]}}, s1Real};
    assign bExt = {{WIDTH{s1Imag[WIDTH-1]}}, s1Imag};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pAA <= '0;
            pBB <= '0;
            pAB <= '0;
        end else if (stageEn) begin
            pAA <= aExt * aExt;
            pBB <= bExt * bExt;
            pAB <= aExt * bExt;
        end
    end

    assign pAAx = {{2{pAA[PW-1]}}, pAA};
    assign pBBx = {{2{pBB[PW-1]}}, pBB};
    assign pABx = {{2{pAB[PW-1]}}, pAB};

    always_comb begin
        if (s2Mode == MODE_MAG2) begin
            sumR = pAAx + pBBx;
            sumI = '0;
        end else begin
            sumR = pAAx - pBBx;
            sumI = pABx + pABx;
        end
    end

`ifdef NCH_CSQ_ROUND_EN
    localparam logic signed [IW-1:0] RND = {{(IW-1){1'b0}}, 1'b1} << (FRAC - 1);
    assign shR = (sumR + RND) >>> FRAC;
    assign shI = (sumI + RND) >>> FRAC;
`else
    assign shR = sumR >>> FRAC;
    assign shI = sumI >>> FRAC;
`endif

    assign satR = saturate(64'(shR), IW, WIDTH);
    assign satI = saturate(64'(shI), IW, WIDTH);

    // Clamped values always fit in WIDTH bits; the upper bits are sign copies.
    assign unusedHigh = ^{satR.value[63:WIDTH], satI.value[63:WIDTH]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outReal <= '0;
            outImag <= '0;
            satFlag <= 1'b0;
        end else if (stageEn) begin
            outReal <= satR.value[WIDTH-1:0];
            outImag <= satI.value[WIDTH-1:0];
            satFlag <= satR.sat | satI.sat;
        end
    end

endmodule

// File: rtl/nch_complex_square.sv
// N-lane complex squarer (z^2 or |z|^2) with valid/ready and a 3-stage pipeline.
// Build option NCH_CSQ_ROUND_EN enables round-half-up scaling in every lane.
module nch_complex_square
    import nch_csq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int FRAC  = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] inReal,
    input  logic [NCH*WIDTH-1:0] inImag,
    input  logic                 inMode,
    input  logic                 inValid,
    output logic                 inReady,
    output logic [NCH*WIDTH-1:0] outReal,
    output logic [NCH*WIDTH-1:0] outImag,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [NCH-1:0]       satFlag
);

    logic [NCH*WIDTH-1:0] s1Real, s1Imag;
    logic                 s1Valid, s1Mode;
    logic                 s2Valid, s2Mode;
    logic                 adv;

    // Single global stall: every stage moves only when the output slot frees up.
    assign adv     = !outValid || outReady;
    assign inReady = adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Real   <= '0;
            s1Imag   <= '0;
            s1Mode   <= MODE_SQUARE;
            s1Valid  <= 1'b0;
            s2Mode   <= MODE_SQUARE;
            s2Valid  <= 1'b0;
            outValid <= 1'b0;
        end else if (adv) begin
            s1Real   <= inReal;
            s1Imag   <= inImag;
            s1Mode   <= inMode;
            s1Valid  <= inValid;
            s2Mode   <= s1Mode;
            s2Valid  <= s1Valid;
            outValid <= s2Valid;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : gLane
        complex_square_lane #(
            .WIDTH (WIDTH),
            .FRAC  (FRAC)
        ) uLane (
            .clk     (clk),
            .rst     (rst),
            .stageEn (adv),
            .s1Real  (s1Real[k*WIDTH +: WIDTH]),
            .s1Imag  (s1Imag[k*WIDTH +: WIDTH]),
            .s2Mode  (s2Mode),
            .outReal (outReal[k*WIDTH +: WIDTH]),
            .outImag (outImag[k*WIDTH +: WIDTH]),
            .satFlag (satFlag[k])
        );
    end

endmodule

// File: tb/tb_nch_complex_square.sv
// Self-checking bench for nch_complex_square: directed vectors, random streams
// with backpressure, a fixed stall window and mid-stream reset.
module tb_nch_complex_square;
    import nch_csq_pkg::*;

    localparam int WIDTH = 16;
    localparam int NCH   = 4;
    localparam int FRAC  = 14;
    localparam int LW    = NCH * WIDTH;
`ifdef NCH_CSQ_ROUND_EN
    localparam int R91 = 1;
`else
    localparam int R91 = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [LW-1:0] inReal = '0, inImag = '0;
    logic          inMode = 1'b0, inValid = 1'b0, outReady = 1'b1;
    logic          inReady, outValid;
    logic [LW-1:0] outReal, outImag;
    logic [NCH-1:0] satFlag;

    int nCompared = 0;
    int nMismatched = 0;

    typedef struct {
        logic [LW-1:0]  re;
        logic [LW-1:0]  im;
        logic [NCH-1:0] sat;
    } exp_t;

    exp_t sb[$];

    nch_complex_square #(.WIDTH(WIDTH), .NCH(NCH), .FRAC(FRAC)) dut (
        .clk      (clk),
        .rst      (rst),
        .inReal   (inReal),
        .inImag   (inImag),
        .inMode   (inMode),
        .inValid  (inValid),
        .inReady  (inReady),
        .outReal  (outReal),
        .outImag  (outImag),
        .outValid (outValid),
        .outReady (outReady),
        .satFlag  (satFlag)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: exact integer square, optional half-LSB bias, floor shift, clamp.
    function automatic exp_t model(input logic [LW-1:0] r, input logic [LW-1:0] i, input logic mode);
        exp_t   e;
        longint a, b, x, y, hi, lo;
        hi = (longint'(1) <<< (WIDTH - 1)) - 1;
        lo = -hi - 1;
        for (int k = 0; k < NCH; k++) begin
            a = longint'($signed(r[k*WIDTH +: WIDTH]));
            b = longint'($signed(i[k*WIDTH +: WIDTH]));
            if (mode) begin
                x = a * a + b * b;
                y = 0;
            end else begin
                x = a * a - b * b;
                y = 2 * a * b;
            end
`ifdef NCH_CSQ_ROUND_EN
            x = x + (longint'(1) <<< (FRAC - 1));
            y = y + (longint'(1) <<< (FRAC - 1));
`endif
            x = x >>> FRAC;
            y = y >>> FRAC;
            e.sat[k] = (x > hi) || (x < lo) || (y > hi) || (y < lo);
            if (x > hi) x = hi;
            if (x < lo) x = lo;
            if (y > hi) y = hi;
            if (y < lo) y = lo;
            e.re[k*WIDTH +: WIDTH] = x[WIDTH-1:0];
            e.im[k*WIDTH +: WIDTH] = y[WIDTH-1:0];
        end
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] rand_comp();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7fff;
            2:       return '0;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    function automatic logic [LW-1:0] rand_vec();
        logic [LW-1:0] v;
        for (int k = 0; k < NCH; k++) v[k*WIDTH +: WIDTH] = rand_comp();
        return v;
    endfunction

    // Sends one beat into an empty pipeline and returns its result and latency in edges.
    task automatic run_single(input logic [LW-1:0] r, input logic [LW-1:0] i, input logic mode,
                              output logic [LW-1:0] gotR, output logic [LW-1:0] gotI,
                              output logic [NCH-1:0] gotS, output int lat);
        @(negedge clk);
        inReal = r; inImag = i; inMode = mode; inValid = 1'b1; outReady = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        lat = 1;
        while (!outValid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!outValid) lat = -1;
        gotR = outReal; gotI = outImag; gotS = satFlag;
    endtask

    task automatic test_reset();
        @(negedge clk);
        nCompared++;
        if (outValid !== 1'b0) begin nMismatched++; $display("FAIL reset_outValid: got %b want 0", outValid); end
        nCompared++;
        if (outReal !== '0 || outImag !== '0) begin
            nMismatched++; $display("FAIL reset_data: got re=%h im=%h want 0", outReal, outImag);
        end
        nCompared++;
        if (satFlag !== '0) begin nMismatched++; $display("FAIL reset_sat: got %b want 0", satFlag); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int   dR[6] = '{8192, 8192, 16384, -32768, 91, 0};
        int   dI[6] = '{8192, 8192, 0, 0, 0, 91};
        logic dM[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int   eR[6] = '{0, 8192, 16384, 32767, R91, -1};
        int   eI[6] = '{8192, 0, 0, 0, 0, 0};
        logic eS[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [LW-1:0]  r, i, gR, gI;
        logic [NCH-1:0] gS;
        int lat;
        for (int n = 0; n < 6; n++) begin
            r = '0; i = '0;
            r[WIDTH-1:0] = WIDTH'(dR[n]);
            i[WIDTH-1:0] = WIDTH'(dI[n]);
            run_single(r, i, dM[n], gR, gI, gS, lat);
            nCompared++;
            if (lat !== CSQ_LATENCY) begin nMismatched++; $display("FAIL dir%0d_latency: got %0d want %0d", n, lat, CSQ_LATENCY); end
            nCompared++;
            if (int'($signed(gR[WIDTH-1:0])) !== eR[n]) begin
                nMismatched++; $display("FAIL dir%0d_real: got %0d want %0d", n, $signed(gR[WIDTH-1:0]), eR[n]);
            end
            nCompared++;
            if (int'($signed(gI[WIDTH-1:0])) !== eI[n]) begin
                nMismatched++; $display("FAIL dir%0d_imag: got %0d want %0d", n, $signed(gI[WIDTH-1:0]), eI[n]);
            end
            nCompared++;
            if (gS[0] !== eS[n]) begin nMismatched++; $display("FAIL dir%0d_sat0: got %b want %b", n, gS[0], eS[n]); end
            nCompared++;
            if (gR[LW-1:WIDTH] !== '0 || gI[LW-1:WIDTH] !== '0 || gS[NCH-1:1] !== '0) begin
                nMismatched++; $display("FAIL dir%0d_other_lanes: got re=%h im=%h sat=%b want 0", n, gR, gI, gS);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random_stream();
        int   recvd = 0, sent = 0;
        exp_t e;
        sb.delete();
        for (int c = 0; c < 320; c++) begin
            @(negedge clk);
            inValid  = (c < 280) && ($urandom_range(0, 3) != 0);
            inReal   = rand_vec();
            inImag   = rand_vec();
            inMode   = 1'($urandom_range(0, 1));
            outReady = (c >= 280) || ($urandom_range(0, 2) != 0);
            #1;
            nCompared++;
            if (inReady !== (!outValid || outReady)) begin
                nMismatched++; $display("FAIL rnd_inReady c%0d: got %b want %b", c, inReady, !outValid || outReady);
            end
            if (outValid) begin
                nCompared++;
                if (sb.size() == 0) begin
                    nMismatched++; $display("FAIL rnd_spurious c%0d: got outValid=1 want no pending beat", c);
                end else begin
                    e = sb[0];
                    if (outReal !== e.re || outImag !== e.im || satFlag !== e.sat) begin
                        nMismatched++;
                        $display("FAIL rnd_data c%0d: got re=%h im=%h sat=%b want re=%h im=%h sat=%b",
                                 c, outReal, outImag, satFlag, e.re, e.im, e.sat);
                    end
                    if (outReady) begin void'(sb.pop_front()); recvd++; end
                end
            end
            if (inValid && inReady) begin sb.push_back(model(inReal, inImag, inMode)); sent++; end
        end
        nCompared++;
        if (sb.size() != 0 || recvd != sent) begin
            nMismatched++; $display("FAIL rnd_drain: got %0d received want %0d", recvd, sent);
        end
        inValid = 1'b0;
    endtask

    task automatic test_stall();
        int   recvd = 0, sent = 0;
        exp_t e;
        logic [LW-1:0] r, i;
        sb.delete();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            for (int k = 0; k < NCH; k++) begin
                r[k*WIDTH +: WIDTH] = WIDTH'(1000 * (sent + 1) + 37 * k);
                i[k*WIDTH +: WIDTH] = WIDTH'(-(700 * (sent + 1)) + 11 * k);
            end
            inReal   = r;
            inImag   = i;
            inMode   = 1'(sent % 2);
            inValid  = (sent < 10);
            outReady = !(c >= 4 && c <= 7);
            #1;
            if (c >= 4 && c <= 7) begin
                nCompared++;
                if (inReady !== 1'b0) begin nMismatched++; $display("FAIL stall_inReady c%0d: got %b want 0", c, inReady); end
            end
            if (outValid) begin
                nCompared++;
                if (sb.size() == 0) begin
                    nMismatched++; $display("FAIL stall_spurious c%0d: got outValid=1 want no pending beat", c);
                end else begin
                    e = sb[0];
                    if (outReal !== e.re || outImag !== e.im || satFlag !== e.sat) begin
                        nMismatched++;
                        $display("FAIL stall_data c%0d: got re=%h im=%h want re=%h im=%h", c, outReal, outImag, e.re, e.im);
                    end
                    if (outReady) begin void'(sb.pop_front()); recvd++; end
                end
            end
            if (inValid && inReady) begin sb.push_back(model(inReal, inImag, inMode)); sent++; end
        end
        nCompared++;
        if (recvd != 10 || sb.size() != 0) begin
            nMismatched++; $display("FAIL stall_count: got %0d received want 10", recvd);
        end
        inValid = 1'b0;
    endtask

    task automatic test_reset_midstream();
        logic [LW-1:0]  r, i, gR, gI;
        logic [NCH-1:0] gS;
        exp_t e;
        int   lat;
        outReady = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            inReal = rand_vec(); inImag = rand_vec(); inMode = 1'b0; inValid = 1'b1;
        end
        @(posedge clk);
        #2;
        inValid = 1'b0;
        rst = 1'b1;
        #1;
        nCompared++;
        if (outValid !== 1'b0) begin nMismatched++; $display("FAIL midrst_outValid: got %b want 0", outValid); end
        nCompared++;
        if (outReal !== '0 || outImag !== '0 || satFlag !== '0) begin
            nMismatched++; $display("FAIL midrst_data: got re=%h im=%h sat=%b want 0", outReal, outImag, satFlag);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            nCompared++;
            if (outValid !== 1'b0) begin nMismatched++; $display("FAIL midrst_flush c%0d: got outValid=%b want 0", c, outValid); end
        end
        r = rand_vec(); i = rand_vec();
        e = model(r, i, 1'b1);
        run_single(r, i, 1'b1, gR, gI, gS, lat);
        nCompared++;
        if (lat !== CSQ_LATENCY) begin nMismatched++; $display("FAIL midrst_latency: got %0d want %0d", lat, CSQ_LATENCY); end
        nCompared++;
        if (gR !== e.re || gI !== e.im || gS !== e.sat) begin
            nMismatched++; $display("FAIL midrst_first: got re=%h im=%h want re=%h im=%h", gR, gI, e.re, e.im);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_stream();
        test_stall();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
